// File: rtl/edge_window_ctrl.sv
// Sequencing controller for the line-buffer + Sobel edge datapath: turns the raster position
// into shift/window strobes, tracks line-buffer fill and latches the per-frame mode.
module edge_window_ctrl #(
    parameter int COLS     = 640,
    parameter int ROWS     = 480,
    parameter int GRAY_LAT = 1,
    parameter int DP_LAT   = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic [1:0]  mode_in,
    output logic        sr_shift,
    output logic        win_valid,
    output logic        out_valid,
    output logic        border,
    output logic [1:0]  mode,
    output logic [1:0]  rows_filled,
    output logic        frame_done
);
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int FW = $clog2(DP_LAT + 1);
    localparam logic [10:0]   COLS_H     = 11'(COLS);
    localparam logic [9:0]    ROWS_V     = 10'(ROWS);
    localparam logic [CW-1:0] COL_LAST   = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(DP_LAT);

    typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] col, col_nxt, pix_col;
    logic [RW-1:0] row, row_nxt, pix_row;
    logic [FW-1:0] flush_cnt, flush_cnt_nxt;
    logic          act_raw, sof_raw, act_p0, sof_p0;
    logic          shift_p0, win_p0, wrap_p0, hold_p0, done_p0;
    logic          wrap_p1, hold_p1;
    logic [DP_LAT-1:0] vld_p2, shf_p2, hold_p2;

    function automatic logic [1:0] sat_inc2(input logic [1:0] v);
        return (v >= 2'd2) ? 2'd2 : v + 2'd1;
    endfunction

    assign act_raw = (hcount < COLS_H) && (vcount < ROWS_V);
    assign sof_raw = (hcount == 11'd0) && (vcount == 10'd0);

    // raster -> p0: align the raster qualifiers so the p1 register lands GRAY_LAT cycles later
    generate
        if (GRAY_LAT > 1) begin : g_gray_dly
            logic [GRAY_LAT-2:0] act_gl, sof_gl;
            always_ff @(posedge clock) begin
                if (reset) begin
                    act_gl <= '0;
                    sof_gl <= '0;
                end else begin
                    act_gl[0] <= act_raw;
                    sof_gl[0] <= sof_raw;
                    for (int i = 1; i < GRAY_LAT - 1; i++) begin
                        act_gl[i] <= act_gl[i-1];
                        sof_gl[i] <= sof_gl[i-1];
                    end
                end
            end
            assign act_p0 = act_gl[GRAY_LAT-2];
            assign sof_p0 = sof_gl[GRAY_LAT-2];
        end else begin : g_gray_dir
            assign act_p0 = act_raw;
            assign sof_p0 = sof_raw;
        end
    endgenerate

    always_comb begin
        state_nxt     = state;
        col_nxt       = col;
        row_nxt       = row;
        flush_cnt_nxt = flush_cnt;
        done_p0       = 1'b0;
        // a SOF in any state restarts the frame with this pixel as (0,0)
        pix_col  = sof_p0 ? '0 : col;
        pix_row  = sof_p0 ? '0 : row;
        hold_p0  = ((sof_p0 ? mode_in : mode) == 2'd3);
        shift_p0 = act_p0 && (sof_p0 || state == FILL || state == RUN);
        wrap_p0  = shift_p0 && (pix_col == COL_LAST);
        win_p0   = shift_p0 && !sof_p0 && (state == RUN) && (col >= CW'(2));

        if (shift_p0) begin
            col_nxt = wrap_p0 ? '0 : pix_col + 1'b1;
            row_nxt = wrap_p0 ? pix_row + 1'b1 : pix_row;
        end

        if (sof_p0) begin
            state_nxt     = FILL;
            flush_cnt_nxt = '0;
            if (!shift_p0) begin
                col_nxt = '0;
                row_nxt = '0;
            end
        end else begin
            case (state)
                FILL: if (wrap_p0 && row == RW'(1)) state_nxt = RUN;
                RUN: begin
                    if (wrap_p0 && row == ROW_LAST) begin
                        state_nxt     = FLUSH;
                        col_nxt       = '0;
                        row_nxt       = '0;
                        flush_cnt_nxt = '0;
                    end
                end
                FLUSH: begin
                    if (flush_cnt == FLUSH_LAST) begin
                        state_nxt = IDLE;
                        done_p0   = 1'b1;
                    end else begin
                        flush_cnt_nxt = flush_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // p0 -> p1: shift/window strobes at shift-register input timing
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            col         <= '0;
            row         <= '0;
            flush_cnt   <= '0;
            mode        <= 2'd0;
            rows_filled <= 2'd0;
            sr_shift    <= 1'b0;
            win_valid   <= 1'b0;
            wrap_p1     <= 1'b0;
            hold_p1     <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            state      <= state_nxt;
            col        <= col_nxt;
            row        <= row_nxt;
            flush_cnt  <= flush_cnt_nxt;
            sr_shift   <= shift_p0;
            win_valid  <= win_p0;
            wrap_p1    <= wrap_p0;
            hold_p1    <= hold_p0;
            frame_done <= done_p0;
            if (sof_p0) mode <= mode_in;
            if (sof_p0)       rows_filled <= 2'd0;
            else if (wrap_p1) rows_filled <= sat_inc2(rows_filled);
        end
    end

    // p1 -> p2: delay line matching the Sobel/selector latency
    always_ff @(posedge clock) begin
        if (reset) begin
            vld_p2  <= '0;
            shf_p2  <= '0;
            hold_p2 <= '0;
        end else begin
            vld_p2[0]  <= win_valid;
            shf_p2[0]  <= sr_shift;
            hold_p2[0] <= hold_p1;
            for (int i = 1; i < DP_LAT; i++) begin
                vld_p2[i]  <= vld_p2[i-1];
                shf_p2[i]  <= shf_p2[i-1];
                hold_p2[i] <= hold_p2[i-1];
            end
        end
    end

    assign out_valid = vld_p2[DP_LAT-1];
    assign border    = shf_p2[DP_LAT-1] && (hold_p2[DP_LAT-1] || !vld_p2[DP_LAT-1]);

endmodule
